wb_retire_stage: RTL and testbench
==================================

WB_RETIRE_STAGE -- requirements
Module: wb_retire_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width; must be a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 5, register-file address width.
REQ-003 SHALL have parameter PC_W, default 32, PC width.
REQ-004 SHALL have parameter DEPTH, default 2, retire-queue entries; must be a power of two, at least 2.
REQ-005 SHALL define BE_W = DATA_W/8 and BUS_W = 1+ADDR_W+BE_W+DATA_W+PC_W.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 ms_to_ws_valid  in  1  upstream entry valid.
REQ-009 ms_to_ws_bus  in  BUS_W  {gr_we, dest, be, result, pc}, MSB first.
REQ-010 ws_allowin  out  1  queue can accept this cycle.
REQ-011 ws_flush  in  1  discard all queued entries.
REQ-012 rf_ready  in  1  register-file write port accepts this cycle.
REQ-013 rf_we  out  BE_W  byte write enables.
REQ-014 rf_waddr  out  ADDR_W  write address.
REQ-015 rf_wdata  out  DATA_W  write data.
REQ-016 fwd_addr  in  ADDR_W  decode-stage source register query.
REQ-017 fwd_hit  out  1  a queued entry writes fwd_addr.
REQ-018 fwd_data  out  DATA_W  data of the youngest matching entry.
REQ-019 fwd_stall  out  1  youngest match has partial byte enables.
REQ-020 debug_wb_pc / debug_wb_rf_wen / debug_wb_rf_wnum / debug_wb_rf_wdata  out  PC_W / BE_W / ADDR_W / DATA_W  retire trace.

Function
REQ-021 An entry SHALL be pushed on a rising edge when ms_to_ws_valid and ws_allowin are both 1 and ws_flush is 0.
REQ-022 ws_allowin SHALL be 1 exactly when count < DEPTH, with no combinational dependence on rf_ready; a full queue never accepts, even while it pops.
REQ-023 The effective write enable SHALL be be when gr_we is 1 and dest is non-zero, otherwise all zeros.
REQ-024 The head entry SHALL retire (pop) when it is valid and either rf_ready is 1 or its effective write enable is zero.
REQ-025 rf_we SHALL be the head's effective write enable when the head is valid, else 0; rf_waddr and rf_wdata SHALL be driven from the head.
REQ-026 A pushed entry SHALL be retirable no earlier than the cycle after its push: one-cycle minimum latency, no bypass.
REQ-027 A simultaneous push and pop SHALL leave count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-028 ws_flush SHALL set count to 0 and both pointers to 0 at the next edge, overriding push and pop; rf_we is still driven from the head during the flush cycle.
REQ-029 fwd_hit SHALL be 1 when any valid entry has a non-zero effective write enable and dest equal to fwd_addr.
REQ-030 On a hit, fwd_data SHALL come from the youngest such entry, and fwd_stall SHALL be 1 when that entry's effective enable is not all ones.
REQ-031 When there is no hit, fwd_data and fwd_stall SHALL be 0; fwd_addr of 0 SHALL never hit.

Reset
REQ-032 Reset SHALL clear count and pointers, so that ws_allowin = 1 and rf_we, fwd_hit, fwd_stall and debug_wb_rf_wen are 0.
REQ-033 Entry payload storage SHALL not require reset.
REQ-034 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.

Configuration
REQ-035 With macro WB_RETIRE_TRACE_EN defined, the debug_* outputs SHALL present the retiring entry in its pop cycle: pc, effective write enable, dest and result.
REQ-036 With WB_RETIRE_TRACE_EN defined, debug_wb_rf_wen SHALL be 0 in any cycle with no pop.
REQ-037 Without WB_RETIRE_TRACE_EN, the debug_* ports SHALL remain present, tied to 0, and SHALL contain no trace logic.

Verification
REQ-038 Push {we=1, dest=3, be=F, result=0x12345678, pc=0xBFC00000} with rf_ready=1 -> the next cycle shows rf_we=F, rf_waddr=3, rf_wdata=0x12345678, and the trace shows the same pc.
REQ-039 DEPTH=2 with rf_ready=0 and two pushes -> ws_allowin=0 and the third entry is held; raise rf_ready -> pops occur in order over 2 cycles and ws_allowin returns to 1.
REQ-040 Queue dest=5 with be=F (data A), then dest=5 with be=3 (data B), with fwd_addr=5 -> fwd_hit=1, fwd_data=B, fwd_stall=1; after B retires -> fwd_data=A, fwd_stall=0.
REQ-041 Push gr_we=1, dest=0 with rf_ready=0 -> the entry pops anyway, rf_we=0, and fwd_addr=0 gives fwd_hit=0.
REQ-042 Two entries queued, assert ws_flush concurrently with a valid push -> count=0 on the next cycle, the pushed entry is lost, and ws_allowin=1.
REQ-043 Assert reset asynchronously between edges while 1 entry is queued -> rf_we=0 and fwd_hit=0 immediately.

Source files
------------

// File: rtl/wb_retire_stage.sv
// Retire queue between memory and writeback; drives the RF write port and forwards the youngest pending write. Trace: WB_RETIRE_TRACE_EN.
// Latency: an entry is retirable from the cycle after its push (no bypass); flush clears the queue at the next edge.
// Backpressure: ws_allowin = count < DEPTH; the head waits while rf_ready is low, unless it writes no bytes.
module wb_retire_stage #(
  parameter int  DATA_W = 32,
  parameter int  ADDR_W = 5,
  parameter int  PC_W   = 32,
  parameter int  DEPTH  = 2,
  localparam int BE_W   = DATA_W / 8,
  localparam int BUS_W  = 1 + ADDR_W + BE_W + DATA_W + PC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ms_to_ws_valid,
  input  logic [BUS_W-1:0]  ms_to_ws_bus,
  output logic              ws_allowin,
  input  logic              ws_flush,
  input  logic              rf_ready,
  output logic [BE_W-1:0]   rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [ADDR_W-1:0] fwd_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic              fwd_stall,
  output logic [PC_W-1:0]   debug_wb_pc,
  output logic [BE_W-1:0]   debug_wb_rf_wen,
  output logic [ADDR_W-1:0] debug_wb_rf_wnum,
  output logic [DATA_W-1:0] debug_wb_rf_wdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic              gr_we;
    logic [ADDR_W-1:0] dest;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] result;
    logic [PC_W-1:0]   pc;
  } ms_bus_t;

  ms_bus_t           in_bus;
  logic [BE_W-1:0]   in_we;

  logic [BE_W-1:0]   q_we   [DEPTH];
  logic [ADDR_W-1:0] q_dest [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];

  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  fwd_idx;
  logic [CNT_W-1:0]  count;
  logic              head_vld;
  logic              push;
  logic              pop;

  // Writes to r0 are folded into an all-zero enable at entry so they never stall or forward.
  assign in_bus = ms_bus_t'(ms_to_ws_bus);
  assign in_we  = (in_bus.gr_we && (in_bus.dest != '0)) ? in_bus.be : '0;

  assign ws_allowin = (count < CNT_W'(DEPTH));
  assign head_vld   = (count != '0);
  assign push       = ms_to_ws_valid && ws_allowin && !ws_flush;
  assign pop        = head_vld && (rf_ready || (q_we[rd_ptr] == '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (ws_flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_we[wr_ptr]   <= in_we;
      q_dest[wr_ptr] <= in_bus.dest;
      q_data[wr_ptr] <= in_bus.result;
    end
  end

  assign rf_we    = head_vld ? q_we[rd_ptr] : '0;
  assign rf_waddr = q_dest[rd_ptr];
  assign rf_wdata = q_data[rd_ptr];

  // Scan oldest to youngest so the last match found is the youngest.
  always_comb begin
    fwd_hit   = 1'b0;
    fwd_data  = '0;
    fwd_stall = 1'b0;
    fwd_idx   = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (q_we[fwd_idx] != '0) && (q_dest[fwd_idx] == fwd_addr)) begin
        fwd_hit   = 1'b1;
        fwd_data  = q_data[fwd_idx];
        fwd_stall = ~&q_we[fwd_idx];
      end
    end
  end

`ifdef WB_RETIRE_TRACE_EN
  logic [PC_W-1:0] q_pc [DEPTH];

  always_ff @(posedge clk) begin
    if (push) q_pc[wr_ptr] <= in_bus.pc;
  end

  assign debug_wb_pc       = q_pc[rd_ptr];
  assign debug_wb_rf_wen   = pop ? q_we[rd_ptr] : '0;
  assign debug_wb_rf_wnum  = q_dest[rd_ptr];
  assign debug_wb_rf_wdata = q_data[rd_ptr];
`else
  logic unused_pc;
  assign unused_pc         = ^in_bus.pc;
  assign debug_wb_pc       = '0;
  assign debug_wb_rf_wen   = '0;
  assign debug_wb_rf_wnum  = '0;
  assign debug_wb_rf_wdata = '0;
`endif

endmodule

// File: tb/tb_wb_retire_stage.sv
// Directed bench for wb_retire_stage at default parameters: a per-cycle vector table
// followed by hand sequences for backpressure, flush and asynchronous reset.
module tb_wb_retire_stage;

`ifdef WB_RETIRE_TRACE_EN
  localparam bit TRACE = 1'b1;
`else
  localparam bit TRACE = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        ms_to_ws_valid;
  logic [73:0] ms_to_ws_bus;
  logic        ws_allowin;
  logic        ws_flush;
  logic        rf_ready;
  logic [3:0]  rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  fwd_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        fwd_stall;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  int checks = 0;
  int errors = 0;

  wb_retire_stage dut (
    .clk               (clk),
    .reset             (reset),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ws_allowin        (ws_allowin),
    .ws_flush          (ws_flush),
    .rf_ready          (rf_ready),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .fwd_addr          (fwd_addr),
    .fwd_hit           (fwd_hit),
    .fwd_data          (fwd_data),
    .fwd_stall         (fwd_stall),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        vld;
    logic        gr_we;
    logic [4:0]  dest;
    logic [3:0]  be;
    logic [31:0] res;
    logic [31:0] pc;
    logic        rdy;
    logic [4:0]  fa;
    logic        e_allow;
    logic [3:0]  e_we;
    logic        chk_w;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic        e_hit;
    logic [31:0] e_fdata;
    logic        e_stall;
    logic [3:0]  e_dwen;
    logic        chk_pc;
    logic [31:0] e_dpc;
  } vec_t;

  vec_t tv [21];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic apply(input int k, input vec_t v);
    @(negedge clk);
    ms_to_ws_valid = v.vld;
    ms_to_ws_bus   = {v.gr_we, v.dest, v.be, v.res, v.pc};
    rf_ready       = v.rdy;
    fwd_addr       = v.fa;
    ws_flush       = 1'b0;
    #1;
    chk($sformatf("v%0d_allowin", k), 64'(ws_allowin), 64'(v.e_allow));
    chk($sformatf("v%0d_rf_we", k),   64'(rf_we),      64'(v.e_we));
    if (v.chk_w) begin
      chk($sformatf("v%0d_rf_waddr", k), 64'(rf_waddr), 64'(v.e_waddr));
      chk($sformatf("v%0d_rf_wdata", k), 64'(rf_wdata), 64'(v.e_wdata));
    end
    chk($sformatf("v%0d_fwd_hit", k),   64'(fwd_hit),   64'(v.e_hit));
    chk($sformatf("v%0d_fwd_data", k),  64'(fwd_data),  64'(v.e_fdata));
    chk($sformatf("v%0d_fwd_stall", k), 64'(fwd_stall), 64'(v.e_stall));
    chk($sformatf("v%0d_dbg_wen", k),   64'(debug_wb_rf_wen), TRACE ? 64'(v.e_dwen) : 64'h0);
    if (v.chk_pc)
      chk($sformatf("v%0d_dbg_pc", k), 64'(debug_wb_pc), TRACE ? 64'(v.e_dpc) : 64'h0);
  endtask

  task automatic drive(input logic vld, input logic [4:0] dest, input logic [31:0] res,
                       input logic rdy, input logic [4:0] fa, input logic flush);
    @(negedge clk);
    ms_to_ws_valid = vld;
    ms_to_ws_bus   = {1'b1, dest, 4'hF, res, 32'h1000 + res};
    rf_ready       = rdy;
    fwd_addr       = fa;
    ws_flush       = flush;
    #1;
  endtask

  initial begin
    // fields: vld gr_we dest be res pc rdy fa | allow we chk_w waddr wdata | hit fdata stall | dwen chk_pc dpc
    tv[0]  = '{1'b1,1'b1,5'd3,4'hF,32'h12345678,32'hBFC00000,1'b1,5'd3, 1'b1,4'h0,1'b0,5'd0,32'h0,        1'b0,32'h0,1'b0,        4'h0,1'b0,32'h0};
    tv[1]  = '{1'b0,1'b0,5'd0,4'h0,32'h0,32'h0,1'b1,5'd3,                1'b1,4'hF,1'b1,5'd3,32'h12345678, 1'b1,32'h12345678,1'b0, 4'hF,1'b1,32'hBFC00000};
    tv[2]  = '{1'b1,1'b1,5'd5,4'hF,32'hAAAA0001,32'h100,0,5'd5,          1'b1,4'h0,1'b0,5'd0,32'h0,        1'b0,32'h0,1'b0,        4'h0,1'b0,32'h0};
    tv[3]  = '{1'b1,1'b1,5'd5,4'h3,32'hBBBB0002,32'h104,1'b0,5'd5,       1'b1,4'hF,1'b1,5'd5,32'hAAAA0001, 1'b1,32'hAAAA0001,1'b0, 4'h0,1'b0,32'h0};
    tv[4]  = '{1'b0,1'b0,5'd0,4'h0,32'h0,32'h0,1'b0,5'd5,                1'b0,4'hF,1'b1,5'd5,32'hAAAA0001, 1'b1,32'hBBBB0002,1'b1, 4'h0,1'b0,32'h0};
    tv[5]  = '{1'b0,1'b0,5'd0,4'h0,32'h0,32'h0,1'b1,5'd5,                1'b0,4'hF,1'b1,5'd5,32'hAAAA0001, 1'b1,32'hBBBB0002,1'b1, 4'hF,1'b1,32'h100};
    tv[6]  = '{1'b0,1'b0,5'd0,4'h0,32'h0,32'h0,1'b0,5'd5,                1'b1,4'h3,1'b1,5'd5,32'hBBBB0002, 1'b1,32'hBBBB0002,1'b1, 4'h0,1'b0,32'h0};
    tv[7]  = '{1'b0,1'b0,5'd0,4'h0,32'h0,32'h0,1'b1,5'd5,                1'b1,4'h3,1'b1,5'd5,32'hBBBB0002, 1'b1,32'hBBBB0002,1'b1, 4'h3,1'b1,32'h104};
    tv[8]  = '{1'b1,1'b1,5'd0,4'hF,32'hDEAD0000,32'h200,1'b0,5'd0,       1'b1,4'h0,1'b0,5'd0,32'h0,        1'b0,32'h0,1'b0,        4'h0,1'b0,32'h0};
    tv[9]  = '{1'b0,1'b0,5'd0,4'h0,32'h0,32'h0,1'b0,5'd0,                1'b1,4'h0,1'b1,5'd0,32'hDEAD0000, 1'b0,32'h0,1'b0,        4'h0,1'b1,32'h200};
    tv[10] = '{1'b1,1'b1,5'd7,4'hF,32'h77770007,32'h204,1'b0,5'd7,       1'b1,4'h0,1'b0,5'd0,32'h0,        1'b0,32'h0,1'b0,        4'h0,1'b0,32'h0};
    tv[11] = '{1'b0,1'b0,5'd0,4'h0,32'h0,32'h0,1'b0,5'd7,                1'b1,4'hF,1'b1,5'd7,32'h77770007, 1'b1,32'h77770007,1'b0, 4'h0,1'b0,32'h0};
    tv[12] = '{1'b0,1'b0,5'd0,4'h0,32'h0,32'h0,1'b1,5'd7,                1'b1,4'hF,1'b1,5'd7,32'h77770007, 1'b1,32'h77770007,1'b0, 4'hF,1'b1,32'h204};
    tv[13] = '{1'b1,1'b1,5'd9,4'h3,32'h11110009,32'h300,1'b0,5'd9,       1'b1,4'h0,1'b0,5'd0,32'h0,        1'b0,32'h0,1'b0,        4'h0,1'b0,32'h0};
    tv[14] = '{1'b1,1'b1,5'd9,4'hF,32'h22220009,32'h304,1'b0,5'd9,       1'b1,4'h3,1'b1,5'd9,32'h11110009, 1'b1,32'h11110009,1'b1, 4'h0,1'b0,32'h0};
    tv[15] = '{1'b0,1'b0,5'd0,4'h0,32'h0,32'h0,1'b0,5'd9,                1'b0,4'h3,1'b1,5'd9,32'h11110009, 1'b1,32'h22220009,1'b0, 4'h0,1'b0,32'h0};
    tv[16] = '{1'b0,1'b0,5'd0,4'h0,32'h0,32'h0,1'b1,5'd9,                1'b0,4'h3,1'b1,5'd9,32'h11110009, 1'b1,32'h22220009,1'b0, 4'h3,1'b1,32'h300};
    tv[17] = '{1'b0,1'b0,5'd0,4'h0,32'h0,32'h0,1'b1,5'd9,                1'b1,4'hF,1'b1,5'd9,32'h22220009, 1'b1,32'h22220009,1'b0, 4'hF,1'b1,32'h304};
    tv[18] = '{1'b1,1'b0,5'd4,4'hF,32'h44440004,32'h308,1'b0,5'd4,       1'b1,4'h0,1'b0,5'd0,32'h0,        1'b0,32'h0,1'b0,        4'h0,1'b0,32'h0};
    tv[19] = '{1'b0,1'b0,5'd0,4'h0,32'h0,32'h0,1'b0,5'd4,                1'b1,4'h0,1'b1,5'd4,32'h44440004, 1'b0,32'h0,1'b0,        4'h0,1'b1,32'h308};
    tv[20] = '{1'b0,1'b0,5'd0,4'h0,32'h0,32'h0,1'b0,5'd4,                1'b1,4'h0,1'b0,5'd0,32'h0,        1'b0,32'h0,1'b0,        4'h0,1'b0,32'h0};

    reset          = 1'b1;
    ms_to_ws_valid = 1'b0;
    ms_to_ws_bus   = '0;
    ws_flush       = 1'b0;
    rf_ready       = 1'b0;
    fwd_addr       = 5'd3;
    @(negedge clk);
    #1;
    chk("rst_allowin", 64'(ws_allowin), 64'h1);
    chk("rst_rf_we",   64'(rf_we), 64'h0);
    chk("rst_hit",     64'(fwd_hit), 64'h0);
    chk("rst_stall",   64'(fwd_stall), 64'h0);
    chk("rst_dbg_wen", 64'(debug_wb_rf_wen), 64'h0);
    reset = 1'b0;

    for (int k = 0; k < 21; k++) apply(k, tv[k]);

    // Fill with rf_ready low; the third entry must be held, even while the head pops.
    drive(1'b1, 5'd1, 32'h11, 1'b0, 5'd1, 1'b0);
    chk("bp_allow0", 64'(ws_allowin), 64'h1);
    drive(1'b1, 5'd2, 32'h22, 1'b0, 5'd1, 1'b0);
    chk("bp_allow1", 64'(ws_allowin), 64'h1);
    drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd3, 1'b0);
    chk("bp_full_allow", 64'(ws_allowin), 64'h0);
    chk("bp_full_waddr", 64'(rf_waddr), 64'd1);
    chk("bp_held_hit",   64'(fwd_hit), 64'h0);
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd3, 1'b0);
    chk("bp_fullpop_allow", 64'(ws_allowin), 64'h0);
    chk("bp_pop1_we",    64'(rf_we), 64'hF);
    chk("bp_pop1_waddr", 64'(rf_waddr), 64'd1);
    chk("bp_pop1_wdata", 64'(rf_wdata), 64'h11);
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd3, 1'b0);
    chk("bp_pop2_allow", 64'(ws_allowin), 64'h1);
    chk("bp_pop2_waddr", 64'(rf_waddr), 64'd2);
    chk("bp_pop2_wdata", 64'(rf_wdata), 64'h22);
    chk("bp_pop2_hit",   64'(fwd_hit), 64'h0);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0);
    chk("bp_pop3_waddr", 64'(rf_waddr), 64'd3);
    chk("bp_pop3_wdata", 64'(rf_wdata), 64'h33);
    chk("bp_pop3_hit",   64'(fwd_hit), 64'h1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 1'b0);
    chk("bp_empty_we",   64'(rf_we), 64'h0);
    chk("bp_empty_hit",  64'(fwd_hit), 64'h0);

    // Flush with a full queue, then flush overriding an accepted push.
    drive(1'b1, 5'd11, 32'hB1, 1'b0, 5'd12, 1'b0);
    drive(1'b1, 5'd12, 32'hB2, 1'b0, 5'd12, 1'b0);
    chk("fl_nobypass_hit", 64'(fwd_hit), 64'h0);
    drive(1'b1, 5'd13, 32'hB3, 1'b0, 5'd12, 1'b1);
    chk("fl_full_allow", 64'(ws_allowin), 64'h0);
    chk("fl_cycle_we",   64'(rf_we), 64'hF);
    chk("fl_cycle_addr", 64'(rf_waddr), 64'd11);
    chk("fl_cycle_hit",  64'(fwd_hit), 64'h1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd12, 1'b0);
    chk("fl_after_allow", 64'(ws_allowin), 64'h1);
    chk("fl_after_we",    64'(rf_we), 64'h0);
    chk("fl_after_hit",   64'(fwd_hit), 64'h0);
    drive(1'b1, 5'd14, 32'hC1, 1'b0, 5'd14, 1'b0);
    drive(1'b1, 5'd15, 32'hC2, 1'b0, 5'd14, 1'b1);
    chk("fl2_allow", 64'(ws_allowin), 64'h1);
    chk("fl2_fdata", 64'(fwd_data), 64'hC1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd15, 1'b0);
    chk("fl2_lost_hit", 64'(fwd_hit), 64'h0);
    chk("fl2_lost_we",  64'(rf_we), 64'h0);
    drive(1'b1, 5'd16, 32'hC3, 1'b0, 5'd16, 1'b0);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd16, 1'b0);
    chk("fl3_we",    64'(rf_we), 64'hF);
    chk("fl3_waddr", 64'(rf_waddr), 64'd16);
    chk("fl3_wdata", 64'(rf_wdata), 64'hC3);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    chk("fl3_empty_we", 64'(rf_we), 64'h0);

    // Reset raised mid-cycle must empty the queue without a clock edge.
    drive(1'b1, 5'd10, 32'h0A, 1'b0, 5'd10, 1'b0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd10, 1'b0);
    chk("ar_pre_we",  64'(rf_we), 64'hF);
    chk("ar_pre_hit", 64'(fwd_hit), 64'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_we",    64'(rf_we), 64'h0);
    chk("ar_hit",   64'(fwd_hit), 64'h0);
    chk("ar_allow", 64'(ws_allowin), 64'h1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("ar_post_we", 64'(rf_we), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
